// File: rtl/apb_cmd_pkg.sv
// Shared types and constants for the APB command requester and the register
// slaves it drives (ID and R/W register block).
package apb_cmd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  localparam logic [31:0] ID_ADDR  = 32'h0000_0000;
  localparam logic [31:0] RW_ADDR  = 32'h0000_0100;

  localparam logic [31:0] RST_ADDR = 32'h0000_0000;
  localparam logic [31:0] RST_DATA = 32'h0000_0000;

endpackage

// File: rtl/apb_cmd_master.sv
// Single-outstanding APB3 requester: one valid/ready command becomes one
// SETUP/ACCESS transfer, answered by one valid/ready response.
module apb_cmd_master
  import apb_cmd_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic        cmd_write,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] PADDR,
  output logic [31:0] PWDATA,
  output logic        PWRITE,
  output logic        PSEL,
  output logic        PENABLE,
  input  logic [31:0] PRDATA,
  input  logic        PREADY
);

  localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  // Counter value seen during ACCESS cycle number TIMEOUT (cycle 1 -> 0).
  localparam logic [CW-1:0] LAST_CNT = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic            w_timeout;

  assign w_timeout = (TIMEOUT != 0) && (r_cnt == LAST_CNT);

  // NOTE: all state and outputs update with non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= RST_DATA;
      rsp_err   <= 1'b0;
      PADDR     <= RST_ADDR;
      PWDATA    <= RST_DATA;
      PWRITE    <= 1'b0;
      PSEL      <= 1'b0;
      PENABLE   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (cmd_ready && cmd_valid) begin
            cmd_ready <= 1'b0;
            PADDR     <= cmd_addr;
            PWDATA    <= cmd_wdata;
            PWRITE    <= cmd_write;
            PSEL      <= 1'b1;
            r_state   <= ST_SETUP;
          end else begin
            cmd_ready <= 1'b1;
          end
        end

        ST_SETUP: begin
          PENABLE <= 1'b1;
          r_cnt   <= '0;
          r_state <= ST_ACCESS;
        end

        ST_ACCESS: begin
          // A slave answering in the final allowed cycle still completes normally.
          if (PREADY || w_timeout) begin
            rsp_rdata <= (PREADY && !PWRITE) ? PRDATA : RST_DATA;
            rsp_err   <= !PREADY;
            rsp_valid <= 1'b1;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            r_state   <= ST_RESP;
          end else if (r_cnt != '1) begin
            r_cnt <= r_cnt + CW'(1);
          end
        end

        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            r_state   <= ST_IDLE;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_cmd_master.sv
// Self-checking bench: behavioural ID / R-W / memory slave on the APB side,
// a register-level reference model for expected responses.
module tb_apb_cmd_master;
  import apb_cmd_pkg::*;

  localparam int unsigned TMO = 4;

  logic        PCLK = 1'b0;
  logic        PRESETn = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic        cmd_write = 1'b0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic        PWRITE;
  logic        PSEL;
  logic        PENABLE;
  logic [31:0] PRDATA = '0;
  logic        PREADY = 1'b0;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  apb_cmd_master #(.TIMEOUT(TMO)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .cmd_write(cmd_write),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PSEL(PSEL),
    .PENABLE(PENABLE), .PRDATA(PRDATA), .PREADY(PREADY)
  );

  always #5 PCLK = ~PCLK;
  always @(posedge PCLK) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- APB slave (environment) ----------------
  int          s_wait  = 0;
  bit          s_never = 1'b0;
  int          s_ac    = 0;
  int          s_id    = 0;
  logic [31:0] s_rw    = 32'h00FF_0000;
  logic [31:0] s_mem [logic [31:0]];

  initial begin
    forever begin
      @(negedge PCLK);
      if (!PRESETn) begin
        s_id = 0; s_rw = 32'h00FF_0000; s_mem.delete(); s_ac = 0; PREADY = 1'b0;
      end else if (PSEL && PENABLE) begin
        s_ac++;
        if (!s_never && s_ac > s_wait) begin
          PREADY = 1'b1;
          PRDATA = $urandom;
          if (PWRITE) begin
            if (PADDR == ID_ADDR)      s_id = int'(PWDATA % 10);
            else if (PADDR == RW_ADDR) s_rw = PWDATA;
            else                       s_mem[PADDR] = PWDATA;
          end else if (PADDR == ID_ADDR) begin
            PRDATA = 32'hA0 + 32'(s_id);
            s_id = (s_id + 1) % 10;
          end else if (PADDR == RW_ADDR) begin
            PRDATA = s_rw;
          end else begin
            PRDATA = s_mem.exists(PADDR) ? s_mem[PADDR] : (PADDR ^ 32'h5A5A_0000);
          end
        end else begin
          PREADY = 1'b0;
          PRDATA = $urandom;
        end
      end else begin
        s_ac = 0; PREADY = 1'b0; PRDATA = $urandom;
      end
    end
  end

  // ---------------- Reference model ----------------
  int          m_id;
  logic [31:0] m_rw;
  logic [31:0] m_mem [logic [31:0]];

  task automatic model_reset();
    m_id = 0; m_rw = 32'h00FF_0000; m_mem.delete();
  endtask

  // Expected response data of a completed transfer; writes answer 0.
  function automatic logic [31:0] model_xfer(input logic [31:0] addr,
                                             input logic [31:0] wdata,
                                             input logic write);
    logic [31:0] r;
    r = '0;
    if (write) begin
      case (addr)
        ID_ADDR: m_id = int'(wdata % 10);
        RW_ADDR: m_rw = wdata;
        default: m_mem[addr] = wdata;
      endcase
    end else begin
      case (addr)
        ID_ADDR: begin r = 32'hA0 + 32'(m_id); m_id = (m_id + 1) % 10; end
        RW_ADDR: r = m_rw;
        default: r = m_mem.exists(addr) ? m_mem[addr] : (addr ^ 32'h5A5A_0000);
      endcase
    end
    return r;
  endfunction

  // ---------------- Transaction driver ----------------
  // Called at a negedge; returns at the negedge after the response is consumed.
  task automatic do_xfer(input logic [31:0] addr, input logic [31:0] wdata,
                         input logic write, input int waits, input bit never,
                         input int hold, output logic [31:0] rdata,
                         output logic err, output int acc_cyc);
    int n;
    int lat;
    int exp_lat;
    s_wait = waits; s_never = never;
    cmd_addr = addr; cmd_wdata = wdata; cmd_write = write; cmd_valid = 1'b1;
    rdata = '0; err = 1'b0; acc_cyc = 0;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 20) begin
      @(negedge PCLK);
      n++;
    end
    total++;
    if (cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL accept_wait: cmd_ready=%b want 1 within 20 cycles", cmd_ready);
      cmd_valid = 1'b0;
      return;
    end
    @(posedge PCLK);
    #1;
    acc_cyc = cyc;
    cmd_valid = 1'b0; cmd_addr = $urandom; cmd_wdata = $urandom; cmd_write = 1'($urandom);
    lat = 0;
    while (1) begin
      @(negedge PCLK);
      lat++;
      if (rsp_valid === 1'b1 || lat >= 40) break;
      total++;
      if (PSEL !== 1'b1 || PENABLE !== 1'(lat > 1) || cmd_ready !== 1'b0 ||
          PADDR !== addr || PWRITE !== write || (write && PWDATA !== wdata)) begin
        bad++;
        $display("FAIL apb_phase cyc%0d: sel=%b en=%b rdy=%b addr=%h wr=%b wd=%h want sel=1 en=%b rdy=0 addr=%h wr=%b wd=%h",
                 lat, PSEL, PENABLE, cmd_ready, PADDR, PWRITE, PWDATA, 1'(lat > 1), addr, write, wdata);
      end
    end
    exp_lat = never ? int'(2 + TMO) : 3 + waits;
    total++;
    if (rsp_valid !== 1'b1 || lat != exp_lat) begin
      bad++;
      $display("FAIL rsp_latency: rsp_valid=%b at cycle %0d want 1 at cycle %0d", rsp_valid, lat, exp_lat);
    end
    rdata = rsp_rdata; err = rsp_err;
    for (int i = 0; i <= hold; i++) begin
      if (i > 0) @(negedge PCLK);
      total++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== rdata || rsp_err !== err ||
          cmd_ready !== 1'b0 || PSEL !== 1'b0 || PENABLE !== 1'b0) begin
        bad++;
        $display("FAIL rsp_hold %0d: valid=%b rdata=%h err=%b rdy=%b sel=%b en=%b want 1 %h %b 0 0 0",
                 i, rsp_valid, rsp_rdata, rsp_err, cmd_ready, PSEL, PENABLE, rdata, err);
      end
    end
    rsp_ready = 1'b1;
    @(posedge PCLK);
    #1 rsp_ready = 1'b0;
    @(negedge PCLK);
    total++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      bad++;
      $display("FAIL rsp_consume: cmd_ready=%b rsp_valid=%b want 1 0", cmd_ready, rsp_valid);
    end
  endtask

  task automatic apply_reset();
    cmd_valid = 1'b0; rsp_ready = 1'b0; PRESETn = 1'b0;
    repeat (2) @(negedge PCLK);
    PRESETn = 1'b1;
    model_reset();
    @(negedge PCLK);
  endtask

  // ---------------- Tests ----------------
  task automatic test_reset();
    cmd_valid = 1'b1; cmd_addr = RW_ADDR; cmd_write = 1'b1; cmd_wdata = 32'h1234_5678;
    #12;
    total++;
    if ({cmd_ready, rsp_valid, rsp_err, PSEL, PENABLE, PWRITE} !== 6'b0 ||
        rsp_rdata !== 32'h0 || PADDR !== 32'h0 || PWDATA !== 32'h0) begin
      bad++;
      $display("FAIL reset_values: rdy=%b vld=%b err=%b sel=%b en=%b wr=%b rd=%h pa=%h pw=%h want all 0",
               cmd_ready, rsp_valid, rsp_err, PSEL, PENABLE, PWRITE, rsp_rdata, PADDR, PWDATA);
    end
    @(negedge PCLK);
    PRESETn = 1'b1;
    cmd_valid = 1'b0;
    model_reset();
    #1;
    total++;
    if (cmd_ready !== 1'b0) begin
      bad++; $display("FAIL ready_after_release: cmd_ready=%b want 0", cmd_ready);
    end
    @(negedge PCLK);
    total++;
    if (cmd_ready !== 1'b1 || PSEL !== 1'b0) begin
      bad++; $display("FAIL ready_first_edge: cmd_ready=%b psel=%b want 1 0", cmd_ready, PSEL);
    end
  endtask

  task automatic test_id_write_read();
    logic [31:0] rd; logic er; int ac; logic [31:0] ex;
    ex = model_xfer(ID_ADDR, 32'd3, 1'b1);
    do_xfer(ID_ADDR, 32'd3, 1'b1, 0, 1'b0, 0, rd, er, ac);
    total++;
    if (rd !== ex || er !== 1'b0) begin
      bad++; $display("FAIL id_write: rdata=%h err=%b want %h 0", rd, er, ex);
    end
    for (int i = 0; i < 2; i++) begin
      ex = model_xfer(ID_ADDR, 32'd0, 1'b0);
      do_xfer(ID_ADDR, 32'd0, 1'b0, 0, 1'b0, 0, rd, er, ac);
      total++;
      if (rd !== ex || rd !== 32'hA3 + 32'(i) || er !== 1'b0) begin
        bad++; $display("FAIL id_read %0d: rdata=%h err=%b want %h 0", i, rd, er, 32'hA3 + 32'(i));
      end
    end
  endtask

  task automatic test_id_sequence();
    logic [31:0] rd; logic er; int ac; logic [31:0] ex;
    apply_reset();
    for (int i = 0; i < 11; i++) begin
      ex = 32'hA0 + 32'(i % 10);
      void'(model_xfer(ID_ADDR, 32'd0, 1'b0));
      do_xfer(ID_ADDR, 32'd0, 1'b0, i % 3, 1'b0, 0, rd, er, ac);
      total++;
      if (rd !== ex || er !== 1'b0) begin
        bad++; $display("FAIL id_seq %0d: rdata=%h err=%b want %h 0", i, rd, er, ex);
      end
    end
    do_xfer(RW_ADDR, 32'd0, 1'b0, 1, 1'b0, 0, rd, er, ac);
    total++;
    if (rd !== 32'h00FF_0000 || er !== 1'b0) begin
      bad++; $display("FAIL rw_reset_read: rdata=%h err=%b want 00ff0000 0", rd, er);
    end
  endtask

  task automatic test_timeout();
    logic [31:0] rd; logic er; int ac; logic [31:0] ex;
    do_xfer(RW_ADDR, 32'd0, 1'b0, 0, 1'b1, 0, rd, er, ac);
    total++;
    if (rd !== 32'h0 || er !== 1'b1) begin
      bad++; $display("FAIL timeout_read: rdata=%h err=%b want 0 1", rd, er);
    end
    ex = model_xfer(RW_ADDR, 32'd0, 1'b0);
    do_xfer(RW_ADDR, 32'd0, 1'b0, int'(TMO) - 1, 1'b0, 0, rd, er, ac);
    total++;
    if (rd !== ex || er !== 1'b0) begin
      bad++; $display("FAIL ready_last_cycle: rdata=%h err=%b want %h 0", rd, er, ex);
    end
  endtask

  task automatic test_hold();
    logic [31:0] rd; logic er; int ac; logic [31:0] ex;
    ex = model_xfer(32'h204, 32'd0, 1'b0);
    do_xfer(32'h204, 32'd0, 1'b0, 0, 1'b0, 5, rd, er, ac);
    total++;
    if (rd !== ex || er !== 1'b0) begin
      bad++; $display("FAIL hold_read: rdata=%h err=%b want %h 0", rd, er, ex);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic er; int ac; int prev; logic [31:0] ex; logic [31:0] a;
    prev = -1;
    for (int i = 0; i < 4; i++) begin
      a = 32'h210 + 32'(4 * i);
      ex = model_xfer(a, 32'hC0DE_0000 + 32'(i), 1'b1);
      do_xfer(a, 32'hC0DE_0000 + 32'(i), 1'b1, 0, 1'b0, 0, rd, er, ac);
      total++;
      if (rd !== ex || er !== 1'b0 || (prev >= 0 && ac - prev != 4)) begin
        bad++; $display("FAIL b2b %0d: rdata=%h err=%b spacing=%0d want %h 0 4", i, rd, er, ac - prev, ex);
      end
      prev = ac;
    end
  endtask

  task automatic test_random();
    logic [31:0] rd; logic er; int ac; logic [31:0] ex; logic [31:0] a; logic [31:0] wd; logic w;
    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 3))
        0:       a = ID_ADDR;
        1:       a = RW_ADDR;
        default: a = 32'h200 + 32'(4 * $urandom_range(0, 7));
      endcase
      wd = $urandom;
      w  = 1'($urandom);
      ex = model_xfer(a, wd, w);
      do_xfer(a, wd, w, int'($urandom_range(0, 2)), 1'b0, int'($urandom_range(0, 3)), rd, er, ac);
      total++;
      if (rd !== ex || er !== 1'b0) begin
        bad++; $display("FAIL random %0d addr=%h wr=%b: rdata=%h err=%b want %h 0", i, a, w, rd, er, ex);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic er; int ac; logic [31:0] ex;
    s_never = 1'b1;
    cmd_addr = RW_ADDR; cmd_write = 1'b0; cmd_valid = 1'b1;
    @(posedge PCLK);
    #1 cmd_valid = 1'b0;
    repeat (2) @(negedge PCLK);
    total++;
    if (PSEL !== 1'b1 || PENABLE !== 1'b1) begin
      bad++; $display("FAIL mid_in_access: sel=%b en=%b want 1 1", PSEL, PENABLE);
    end
    #2 PRESETn = 1'b0;
    #1;
    total++;
    if ({PSEL, PENABLE, cmd_ready, rsp_valid} !== 4'b0) begin
      bad++; $display("FAIL mid_reset_async: sel=%b en=%b rdy=%b vld=%b want 0 0 0 0",
                      PSEL, PENABLE, cmd_ready, rsp_valid);
    end
    repeat (2) @(negedge PCLK);
    PRESETn = 1'b1;
    model_reset();
    for (int i = 0; i < 6; i++) begin
      @(negedge PCLK);
      total++;
      if (rsp_valid !== 1'b0 || PSEL !== 1'b0) begin
        bad++; $display("FAIL no_stale_rsp %0d: vld=%b sel=%b want 0 0", i, rsp_valid, PSEL);
      end
    end
    ex = model_xfer(ID_ADDR, 32'd0, 1'b0);
    do_xfer(ID_ADDR, 32'd0, 1'b0, 0, 1'b0, 0, rd, er, ac);
    total++;
    if (rd !== ex || rd !== 32'hA0 || er !== 1'b0) begin
      bad++; $display("FAIL after_mid_reset: rdata=%h err=%b want 000000a0 0", rd, er);
    end
  endtask

  initial begin
    test_reset();
    test_id_write_read();
    test_id_sequence();
    test_timeout();
    test_hold();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/apb_cmd_master.md
# apb_cmd_master

Single-outstanding APB3 requester that turns a valid/ready command stream (address, write data, direction) into one APB SETUP/ACCESS transfer and returns a valid/ready response carrying read data and an error flag. It sits directly upstream of the APB register slaves (ID/R_W register block) and is the only driver of their PSEL/PENABLE/PADDR/PWDATA/PWRITE. A programmable timeout terminates transfers whose slave never asserts PREADY.

## Interface
- TIMEOUT, 16, max ACCESS cycles waited for PREADY; 0 disables timeout (wait forever)
- PCLK  in  1  clock; all state on rising edge
- PRESETn  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
- cmd_addr  in  32  APB address
- cmd_wdata  in  32  write data (ignored for reads)
- cmd_write  in  1  1 = write, 0 = read
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed when rsp_valid & rsp_ready
- rsp_rdata  out  32  read data; 0 for writes and errors
- rsp_err  out  1  1 = transfer timed out
- PADDR  out  32  APB address
- PWDATA  out  32  APB write data
- PWRITE  out  1  APB direction
- PSEL  out  1  APB select
- PENABLE  out  1  APB enable
- PRDATA  in  32  APB read data
- PREADY  in  1  APB ready

## Operation
- States IDLE, SETUP, ACCESS, RESP; reset state IDLE.
- IDLE: cmd_ready=1; on cmd_valid capture addr/wdata/write into PADDR/PWDATA/PWRITE -> SETUP.
- SETUP: PSEL=1, PENABLE=0 -> ACCESS unconditionally.
- ACCESS: PSEL=1, PENABLE=1; PADDR/PWDATA/PWRITE stable. PREADY=1 -> capture PRDATA (reads) else 0 (writes) into rsp_rdata, rsp_err=0 -> RESP.
- Timeout: counter cleared on entry to ACCESS, increments each ACCESS cycle with PREADY=0. If PREADY=0 in ACCESS cycle number TIMEOUT (first ACCESS cycle = 1): rsp_rdata=0, rsp_err=1 -> RESP. PREADY=1 in that same cycle wins (normal completion). Counter width $clog2(TIMEOUT+1), saturates; never wraps.
- RESP: rsp_valid=1, PSEL=PENABLE=0; rsp_rdata/rsp_err held stable until rsp_ready -> IDLE.
- cmd_ready=0 in SETUP, ACCESS, RESP; no command accepted while a response is pending.
- PADDR/PWDATA/PWRITE hold last transfer values between transfers (no glitching to 0).

## Timing
- Reset values (async, immediate on PRESETn fall): cmd_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, PSEL=0, PENABLE=0, PADDR=0, PWDATA=0, PWRITE=0. cmd_ready rises the first PCLK edge after PRESETn deasserts. All outputs registered.
- Command accepted at edge T: SETUP in cycle T+1, ACCESS from T+2; zero-wait slave -> rsp_valid at T+3. Each PREADY wait cycle adds one.
- rsp_ready high when rsp_valid rises: IDLE (cmd_ready=1) next cycle; minimum command-to-command spacing 4 cycles.
- Reset mid-transfer: PSEL/PENABLE drop asynchronously, in-flight command and pending response discarded, no response issued.
- rsp_ready while rsp_valid=0 ignored; cmd_valid during reset ignored.

## Structure
- Shared package apb_cmd_pkg: state enum (IDLE/SETUP/ACCESS/RESP), register address constants ID_ADDR=32'h0, RW_ADDR=32'h100, reset value constants.
- Single module; no sub-module. Timeout counter inline.

## Test plan
- Reset, write ID=3 then read ID, zero-wait slave -> read rsp_rdata=0x000000A3, rsp_err=0; second read ID -> 0x000000A4.
- Read ID ten times from reset -> 0xA0..0xA9, eleventh -> 0xA0 (wrap); read 0x100 -> 0x00FF0000.
- Timing: command accepted at edge T -> PSEL=1/PENABLE=0 at T+1, PENABLE=1 at T+2, rsp_valid at T+3; PADDR stable T+1..T+2.
- TIMEOUT=4, PREADY tied 0 -> exactly 4 ACCESS cycles, rsp_err=1, rsp_rdata=0; repeat with PREADY=1 in 4th ACCESS cycle -> rsp_err=0, PRDATA returned.
- rsp_ready held low 5 cycles -> rsp_valid and data stable, cmd_ready=0, PSEL=0 throughout; consumed -> cmd_ready=1 next cycle.
- PRESETn asserted mid-ACCESS -> PSEL/PENABLE/cmd_ready/rsp_valid 0 immediately; after release, no stale response, new command completes normally.
